// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular reorder buffer. Allocates tags (1..ROB_SIZE) at decode, captures
//   results from the RS and LSB common data buses, answers operand-readiness
//   queries combinationally, and retires one entry per cycle in program order.
//   A retiring entry that carries a branch mispredict raises flush and wipes
//   the whole buffer.
//
// Ports
//   clk, rst_in (sync, active-high), rdy_in (0 freezes all state)
//   dec2rob_en/dec_rd           : allocate one entry; newTag/isFull report tail/full
//   dep1/2, rf_val1/2           : operand query; label1/2, ready1/2, res1/2 answer it
//   rs_cdb_*                    : ALU write-back, including branch outcome
//   lsb_cdb_*                   : load/store write-back
//   commit_en/lab/val/rd        : registered retire broadcast (one-cycle pulse)
//   flush/flush_pc              : registered redirect on mispredicted branch
module reorder_buffer #(
    parameter int ROB_SIZE     = 8,
    parameter int ROB_ID_WIDTH = 4,
    parameter int VAL_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    dec2rob_en,
    input  logic [4:0]              dec_rd,
    output logic [ROB_ID_WIDTH-1:0] newTag,
    output logic                    isFull,
    input  logic [ROB_ID_WIDTH-1:0] dep1,
    input  logic [ROB_ID_WIDTH-1:0] dep2,
    input  logic [VAL_WIDTH-1:0]    rf_val1,
    input  logic [VAL_WIDTH-1:0]    rf_val2,
    output logic [ROB_ID_WIDTH-1:0] label1,
    output logic [ROB_ID_WIDTH-1:0] label2,
    output logic                    ready1,
    output logic                    ready2,
    output logic [VAL_WIDTH-1:0]    res1,
    output logic [VAL_WIDTH-1:0]    res2,
    input  logic                    rs_cdb_en,
    input  logic [ROB_ID_WIDTH-1:0] rs_cdb2lab,
    input  logic [VAL_WIDTH-1:0]    rs_cdb2val,
    input  logic                    rs_cdb_mispredict,
    input  logic [ADDR_WIDTH-1:0]   rs_cdb_newpc,
    input  logic                    lsb_cdb_en,
    input  logic [ROB_ID_WIDTH-1:0] lsb_cdb2lab,
    input  logic [VAL_WIDTH-1:0]    lsb_cdb2val,
    output logic                    commit_en,
    output logic [ROB_ID_WIDTH-1:0] commit_lab,
    output logic [VAL_WIDTH-1:0]    commit_val,
    output logic [4:0]              commit_rd,
    output logic                    flush,
    output logic [ADDR_WIDTH-1:0]   flush_pc
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic                  busy;
        logic                  ready;
        logic [VAL_WIDTH-1:0]  value;
        logic [4:0]            rd;
        logic                  mispredict;
        logic [ADDR_WIDTH-1:0] newpc;
    } entry_t;

    entry_t                  entries_q [ROB_SIZE];
    entry_t                  entries_d [ROB_SIZE];
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                    commit_en_q, commit_en_d, flush_q, flush_d;
    logic [ROB_ID_WIDTH-1:0] commit_lab_q, commit_lab_d;
    logic [VAL_WIDTH-1:0]    commit_val_q, commit_val_d;
    logic [4:0]              commit_rd_q, commit_rd_d;
    logic [ADDR_WIDTH-1:0]   flush_pc_q, flush_pc_d;

    logic [IDX_W-1:0]        head_idx, tail_idx;
    logic                    do_commit, do_alloc;

    // Entry i holds tag i+1; tag 0 is reserved for "no dependency".
    function automatic logic [ROB_ID_WIDTH-1:0] tag_of(input int i);
        return ROB_ID_WIDTH'(i + 1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROB_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    // Operand lookup: {ready, value}. Live CDB traffic bypasses stored state,
    // RS CDB taking priority over LSB CDB.
    function automatic logic [VAL_WIDTH:0] lookup(input logic [ROB_ID_WIDTH-1:0] dep,
                                                  input logic [VAL_WIDTH-1:0]    rf_val);
        logic [VAL_WIDTH:0] r;
        r = {1'b0, rf_val};
        if (dep != '0) begin
            r = '0;
            if (rs_cdb_en && rs_cdb2lab == dep) begin
                r = {1'b1, rs_cdb2val};
            end else if (lsb_cdb_en && lsb_cdb2lab == dep) begin
                r = {1'b1, lsb_cdb2val};
            end else begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (dep == tag_of(i) && entries_q[i].ready) begin
                        r = {1'b1, entries_q[i].value};
                    end
                end
            end
        end
        return r;
    endfunction

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign isFull   = (count_q == PTR_W'(ROB_SIZE));
    assign newTag   = ROB_ID_WIDTH'(tail_q) + ROB_ID_WIDTH'(1);
    assign label1   = dep1;
    assign label2   = dep2;

    always_comb begin
        {ready1, res1} = lookup(dep1, rf_val1);
        {ready2, res2} = lookup(dep2, rf_val2);
    end

    // Pulses are also masked combinationally so a stall hides a pending one.
    assign commit_en  = commit_en_q & rdy_in;
    assign flush      = flush_q & rdy_in;
    assign commit_lab = commit_lab_q;
    assign commit_val = commit_val_q;
    assign commit_rd  = commit_rd_q;
    assign flush_pc   = flush_pc_q;

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
        entries_d    = entries_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        commit_en_d  = 1'b0;
        flush_d      = 1'b0;
        commit_lab_d = commit_lab_q;
        commit_val_d = commit_val_q;
        commit_rd_d  = commit_rd_q;
        flush_pc_d   = flush_pc_q;
        do_commit    = 1'b0;
        do_alloc     = 1'b0;

        if (rdy_in) begin
            // Write-back only touches entries that were busy before this edge.
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (entries_q[i].busy) begin
                    if (rs_cdb_en && rs_cdb2lab == tag_of(i)) begin
                        entries_d[i].ready      = 1'b1;
                        entries_d[i].value      = rs_cdb2val;
                        entries_d[i].mispredict = rs_cdb_mispredict;
                        entries_d[i].newpc      = rs_cdb_newpc;
                    end else if (lsb_cdb_en && lsb_cdb2lab == tag_of(i)) begin
                        entries_d[i].ready = 1'b1;
                        entries_d[i].value = lsb_cdb2val;
                    end
                end
            end

            do_commit = entries_q[head_idx].busy && entries_q[head_idx].ready;
            do_alloc  = dec2rob_en && !isFull;

            if (do_commit) begin
                commit_en_d         = 1'b1;
                commit_lab_d        = ROB_ID_WIDTH'(head_q) + ROB_ID_WIDTH'(1);
                commit_val_d        = entries_q[head_idx].value;
                commit_rd_d         = entries_q[head_idx].rd;
                entries_d[head_idx] = '0;
                head_d              = ptr_inc(head_q);
            end

            if (do_commit && entries_q[head_idx].mispredict) begin
                // Wrong-path work is discarded, including a same-cycle allocate.
                flush_d    = 1'b1;
                flush_pc_d = entries_q[head_idx].newpc;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries_d[i] = '0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (do_alloc) begin
                    entries_d[tail_idx]      = '0;
                    entries_d[tail_idx].busy = 1'b1;
                    entries_d[tail_idx].rd   = dec_rd;
                    tail_d                   = ptr_inc(tail_q);
                end
                if (do_alloc && !do_commit) begin
                    count_d = count_q + 1'b1;
                end else if (do_commit && !do_alloc) begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            // NOTE: the entry array is reset because busy/ready must start clear; it is small.
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_en_q  <= 1'b0;
            flush_q      <= 1'b0;
            commit_lab_q <= '0;
            commit_val_q <= '0;
            commit_rd_q  <= '0;
            flush_pc_q   <= '0;
        end else begin
            entries_q    <= entries_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            commit_en_q  <= commit_en_d;
            flush_q      <= flush_d;
            commit_lab_q <= commit_lab_d;
            commit_val_q <= commit_val_d;
            commit_rd_q  <= commit_rd_d;
            flush_pc_q   <= flush_pc_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Directed scenarios followed by a randomized phase. A queue of in-flight
//   instructions (oldest first) predicts retirement, flushes and operand
//   queries cycle by cycle.
module tb_reorder_buffer;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, dec2rob_en;
    logic [4:0]  dec_rd;
    logic [3:0]  newTag;
    logic        isFull;
    logic [3:0]  dep1, dep2, label1, label2;
    logic [31:0] rf_val1, rf_val2, res1, res2;
    logic        ready1, ready2;
    logic        rs_cdb_en, rs_cdb_mispredict;
    logic [3:0]  rs_cdb2lab;
    logic [31:0] rs_cdb2val, rs_cdb_newpc;
    logic        lsb_cdb_en;
    logic [3:0]  lsb_cdb2lab;
    logic [31:0] lsb_cdb2val;
    logic        commit_en, flush;
    logic [3:0]  commit_lab;
    logic [31:0] commit_val, flush_pc;
    logic [4:0]  commit_rd;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec2rob_en(dec2rob_en), .dec_rd(dec_rd), .newTag(newTag), .isFull(isFull),
        .dep1(dep1), .dep2(dep2), .rf_val1(rf_val1), .rf_val2(rf_val2),
        .label1(label1), .label2(label2), .ready1(ready1), .ready2(ready2),
        .res1(res1), .res2(res2),
        .rs_cdb_en(rs_cdb_en), .rs_cdb2lab(rs_cdb2lab), .rs_cdb2val(rs_cdb2val),
        .rs_cdb_mispredict(rs_cdb_mispredict), .rs_cdb_newpc(rs_cdb_newpc),
        .lsb_cdb_en(lsb_cdb_en), .lsb_cdb2lab(lsb_cdb2lab), .lsb_cdb2val(lsb_cdb2val),
        .commit_en(commit_en), .commit_lab(commit_lab), .commit_val(commit_val),
        .commit_rd(commit_rd), .flush(flush), .flush_pc(flush_pc)
    );

    typedef struct {
        int          tag;
        int          rd;
        bit          done;
        logic [31:0] val;
        bit          mp;
        logic [31:0] npc;
    } mentry_t;

    mentry_t rob_m[$];
    int      next_tag = 1;
    int      total = 0;
    int      bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model_query(input int dep, input logic [31:0] rf);
        if (dep == 0) return {1'b0, rf};
        if (rs_cdb_en && int'(rs_cdb2lab) == dep) return {1'b1, rs_cdb2val};
        if (lsb_cdb_en && int'(lsb_cdb2lab) == dep) return {1'b1, lsb_cdb2val};
        foreach (rob_m[i]) begin
            if (rob_m[i].tag == dep && rob_m[i].done) return {1'b1, rob_m[i].val};
        end
        return 33'd0;
    endfunction

    function automatic int pick_tag();
        if (rob_m.size() > 0 && $urandom_range(0, 3) != 0)
            return rob_m[$urandom_range(0, rob_m.size() - 1)].tag;
        return $urandom_range(0, N);
    endfunction

    task automatic clear_inputs();
        dec2rob_en = 1'b0; dec_rd = '0;
        rs_cdb_en = 1'b0; rs_cdb2lab = '0; rs_cdb2val = '0;
        rs_cdb_mispredict = 1'b0; rs_cdb_newpc = '0;
        lsb_cdb_en = 1'b0; lsb_cdb2lab = '0; lsb_cdb2val = '0;
        dep1 = '0; dep2 = '0; rf_val1 = '0; rf_val2 = '0;
    endtask

    task automatic alloc_in(input int rd);
        dec2rob_en = 1'b1;
        dec_rd     = 5'(rd);
    endtask

    task automatic rs_wb(input int tag, input logic [31:0] val, input bit mp, input logic [31:0] npc);
        rs_cdb_en = 1'b1; rs_cdb2lab = 4'(tag); rs_cdb2val = val;
        rs_cdb_mispredict = mp; rs_cdb_newpc = npc;
    endtask

    task automatic lsb_wb(input int tag, input logic [31:0] val);
        lsb_cdb_en = 1'b1; lsb_cdb2lab = 4'(tag); lsb_cdb2val = val;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        rob_m.delete();
        next_tag = 1;
        check("rst_newTag", newTag, 1);
        check("rst_isFull", isFull, 0);
        check("rst_commit_en", commit_en, 0);
        check("rst_flush", flush, 0);
        check("rst_commit_lab", commit_lab, 0);
        check("rst_commit_val", commit_val, 0);
        check("rst_commit_rd", commit_rd, 0);
        check("rst_flush_pc", flush_pc, 0);
    endtask

    // One clock: check queries against pre-edge state, advance the model,
    // take the edge, then check the registered outputs.
    task automatic step();
        logic [32:0] q1, q2;
        bit          exp_c, exp_f, alloc;
        mentry_t     fr;
        #1;
        q1 = model_query(int'(dep1), rf_val1);
        q2 = model_query(int'(dep2), rf_val2);
        check("label1", label1, dep1);
        check("label2", label2, dep2);
        check("ready1", ready1, q1[32]);
        check("res1", res1, q1[31:0]);
        check("ready2", ready2, q2[32]);
        check("res2", res2, q2[31:0]);

        fr    = '{tag: 0, rd: 0, done: 0, val: 0, mp: 0, npc: 0};
        exp_c = rdy_in && rob_m.size() > 0 && rob_m[0].done;
        if (exp_c) fr = rob_m[0];
        exp_f = exp_c && fr.mp;
        if (rdy_in) begin
            alloc = dec2rob_en && rob_m.size() < N;
            foreach (rob_m[i]) begin
                if (rs_cdb_en && int'(rs_cdb2lab) == rob_m[i].tag) begin
                    rob_m[i].done = 1; rob_m[i].val = rs_cdb2val;
                    rob_m[i].mp = rs_cdb_mispredict; rob_m[i].npc = rs_cdb_newpc;
                end else if (lsb_cdb_en && int'(lsb_cdb2lab) == rob_m[i].tag) begin
                    rob_m[i].done = 1; rob_m[i].val = lsb_cdb2val;
                end
            end
            if (exp_f) begin
                rob_m.delete();
                next_tag = 1;
            end else begin
                if (exp_c) void'(rob_m.pop_front());
                if (alloc) begin
                    rob_m.push_back('{tag: next_tag, rd: int'(dec_rd), done: 0, val: 0, mp: 0, npc: 0});
                    next_tag = next_tag % N + 1;
                end
            end
        end

        @(posedge clk);
        #1;
        check("commit_en", commit_en, exp_c);
        if (exp_c) begin
            check("commit_lab", commit_lab, fr.tag);
            check("commit_val", commit_val, fr.val);
            check("commit_rd", commit_rd, fr.rd);
        end
        check("flush", flush, exp_f);
        if (exp_f) check("flush_pc", flush_pc, fr.npc);
        check("newTag", newTag, next_tag);
        check("isFull", isFull, rob_m.size() == N);
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rdy_in = 1'b1;
        rst_in = 1'b1;
        do_reset();

        // In-order retirement with out-of-order completion.
        alloc_in(5); step();
        alloc_in(6); step();
        alloc_in(7); step();
        rs_wb(3, 32'h33, 0, 0); step();
        rs_wb(1, 32'h11, 0, 0); step();
        rs_wb(2, 32'h22, 0, 0); step();
        repeat (3) step();

        // Bypass from the live CDB and the "no dependency" path.
        do_reset();
        alloc_in(1); step();
        alloc_in(2); step();
        dep1 = 4'd2; rs_wb(2, 32'hABCD, 0, 0);
        dep2 = 4'd0; rf_val2 = 32'd9;
        #1;
        check("byp_ready1", ready1, 1);
        check("byp_res1", res1, 32'hABCD);
        check("byp_ready2", ready2, 0);
        check("byp_res2", res2, 9);
        step();
        dep1 = 4'd2; dep2 = 4'd1; step();

        // Full, ignored allocate, and wrap (reset above discards pending entries).
        do_reset();
        for (int i = 0; i < N; i++) begin
            check("fill_newTag", newTag, i + 1);
            alloc_in(i + 1); step();
        end
        check("full_isFull", isFull, 1);
        alloc_in(31); step();
        rs_wb(1, 32'h101, 0, 0); step();
        rs_wb(2, 32'h102, 0, 0); step();
        rs_wb(3, 32'h103, 0, 0); step();
        step();
        for (int i = 0; i < 3; i++) begin
            check("wrap_newTag", newTag, i + 1);
            alloc_in(20 + i); step();
        end
        for (int t = N; t >= 1; t--) begin
            rs_wb(t, 32'h200 + t, 0, 0); step();
        end
        repeat (10) step();

        // Mispredict: tag 2 flushes, tags 3 and 4 never retire.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_in(10 + i); step();
        end
        rs_wb(2, 32'h22, 1, 32'h100); step();
        rs_wb(1, 32'h11, 0, 0); step();
        rs_wb(3, 32'h33, 0, 0); step();
        rs_wb(4, 32'h44, 0, 0); alloc_in(9); step();
        check("mp_flush", flush, 1);
        check("mp_flush_pc", flush_pc, 32'h100);
        step();
        check("mp_newTag", newTag, 1);
        check("mp_isFull", isFull, 0);
        repeat (3) step();

        // Stall with a ready head, then dual-CDB priority.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_in(i + 1); step();
        end
        rs_wb(1, 32'h55, 0, 0); step();
        rdy_in = 1'b0;
        repeat (3) begin
            alloc_in(3); rs_wb(2, 32'h66, 0, 0); step();
        end
        check("stall_newTag", newTag, 5);
        rdy_in = 1'b1;
        step();
        rs_wb(2, 32'h2, 0, 0); step();
        rs_wb(3, 32'h3, 0, 0); step();
        rs_wb(4, 32'h1, 0, 0); lsb_wb(4, 32'h2); step();
        repeat (4) step();

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) != 0) alloc_in($urandom_range(0, 31));
            if ($urandom_range(0, 1) != 0)
                rs_wb(pick_tag(), $urandom(), ($urandom_range(0, 15) == 0), $urandom());
            if ($urandom_range(0, 2) == 0) lsb_wb(pick_tag(), $urandom());
            dep1 = 4'(pick_tag()); dep2 = 4'(pick_tag());
            rf_val1 = $urandom(); rf_val2 = $urandom();
            step();
        end
        rdy_in = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer that allocates the ROB tags consumed by `reservationStation` and the load/store buffer. It captures results broadcast on both CDBs, answers operand-readiness queries at issue, and retires instructions strictly in program order. Commit drives the `commit_en`/`commit_lab`/`commit_val` broadcast that the reservation station snoops. It also raises the pipeline-wide `flush` on a mispredicted branch.

## Interface
- `ROB_SIZE`, 8: number of entries; power of two.
- `ROB_ID_WIDTH`, 4: tag width. Tags run 1..`ROB_SIZE`; tag 0 means "no dependency".
- `VAL_WIDTH`, 32: data width.
- `ADDR_WIDTH`, 32: PC width.
- `clk` in 1: the single clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: when 0, all state is frozen and `commit_en`/`flush` are driven 0.
- `dec2rob_en` in 1: allocate one entry this cycle.
- `dec_rd` in 5: destination register; 0 means none (stores, branches).
- `newTag` out `ROB_ID_WIDTH`: tag the next allocation receives (tail index + 1).
- `isFull` out 1: count == `ROB_SIZE`.
- `dep1`, `dep2` in `ROB_ID_WIDTH`: producer tags from the register file; 0 means the value is architectural.
- `rf_val1`, `rf_val2` in `VAL_WIDTH`: register-file values.
- `label1`, `label2` out `ROB_ID_WIDTH`: equal to `dep1`, `dep2`.
- `ready1`, `ready2` out 1: the dependency's result is already available.
- `res1`, `res2` out `VAL_WIDTH`: operand value.
- `rs_cdb_en`, `rs_cdb2lab`, `rs_cdb2val` in: ALU result broadcast.
- `rs_cdb_mispredict` in 1, `rs_cdb_newpc` in `ADDR_WIDTH`: branch outcome, sampled with `rs_cdb_en`.
- `lsb_cdb_en`, `lsb_cdb2lab`, `lsb_cdb2val` in: load/store result broadcast.
- `commit_en` out 1, `commit_lab` out `ROB_ID_WIDTH`, `commit_val` out `VAL_WIDTH`, `commit_rd` out 5: retire broadcast.
- `flush` out 1, `flush_pc` out `ADDR_WIDTH`: redirect on mispredict.

## Operation
- Per-entry state: `busy`, `ready`, `value`, `rd`, `mispredict`, `newpc`. Head pointer, tail pointer and `count` are `log2(ROB_SIZE)+1` bits; the pointers wrap modulo `ROB_SIZE`.
- **Allocate.** When `dec2rob_en && !isFull`, the tail entry gets `busy=1`, `ready=0`, `rd=dec_rd`, `mispredict=0`, and tail increments. `dec2rob_en` while full is ignored.
- **Write-back.** For each enabled CDB whose tag matches a busy entry: set `ready=1` and `value=val`. The RS CDB also writes `mispredict` and `newpc`. If both CDBs carry the same tag, the RS CDB wins. A tag matching a non-busy entry is ignored.
- **Query** (combinational). If `depN==0`: `readyN=0`, `resN=rf_val`. Otherwise:
  - if an enabled CDB carries `depN` this cycle, `readyN=1` and `resN` is that CDB's value (RS CDB first);
  - else if the entry is ready, `readyN=1` and `resN` is its stored value;
  - else `readyN=0` and `resN=0`.
- **Commit.** At most one entry per cycle, at the head. The head commits when `busy && ready` in registered state.
  - Registered outputs for one cycle: `commit_en=1`, `commit_lab=head+1`, `commit_val=value`, `commit_rd=rd`. The head entry is cleared, head increments, `count` decrements.
  - If the committing entry has `mispredict=1`, `flush=1` and `flush_pc=newpc` in the same cycle as `commit_en`. All entries are cleared and head = tail = `count` = 0 on that edge.
- **Simultaneous allocate and commit:** `count` is unchanged and both pointers advance.
- **Flush input path:** `flush` is produced only here. An allocate in the same cycle as a mispredict commit is dropped.

## Timing
- **Reset** (`rst_in` high at a rising edge): all entries cleared, pointers and `count` 0.
  - Outputs after reset: `commit_en=0`, `commit_lab=0`, `commit_val=0`, `commit_rd=0`, `flush=0`, `flush_pc=0`, `newTag=1`, `isFull=0`.
  - Reset mid-operation discards every entry with no commit.
- **Write-back to commit latency:** CDB write-back at edge N; the head commits at edge N+1, so `commit_en` is high during cycle N+1..N+2. This gives a minimum of 2 edges from allocation to `commit_en`.
- **Output pulses:** `commit_en` and `flush` are single-cycle pulses. After an edge with no commit they are 0.
- **`isFull`:** derived from registered `count`. A commit on the same edge does not free a slot for a same-cycle allocate.
- **Flush recovery:** one cycle after a `flush` edge, `newTag=1` and `isFull=0`.

## Test plan
- **Reset.** Hold `rst_in` for 2 cycles → `newTag=1`, `isFull=0`, `commit_en=0`, `flush=0`.
- **In-order retirement.** Allocate tags 1, 2, 3 (`rd` = 5, 6, 7). RS CDB writes tag 3 = 0x33, then tag 1 = 0x11, then tag 2 = 0x22. Required:
  - commits in order: tag 1 (0x11, rd 5), then tag 2 (0x22, rd 6), then tag 3 (0x33, rd 7);
  - tag 1 commits the cycle after its write-back, tags 2 and 3 on consecutive cycles;
  - `commit_en` never asserts before tag 1 is ready.
- **Bypass.** Set `dep1=2` while `rs_cdb_en` broadcasts tag 2 = 0xABCD → `ready1=1` and `res1=0xABCD` in the same cycle. Set `dep2=0`, `rf_val2=9` → `ready2=0`, `res2=9`.
- **Full and wrap.** Allocate 8 entries → `isFull=1` and a 9th `dec2rob_en` is ignored. Complete and commit 3 entries, then allocate 3 more → new tags are 1, 2, 3 and commit order stays FIFO across the wrap.
- **Mispredict.** Allocate tags 1–4. Tag 2 completes with `mispredict=1`, `newpc=0x100`; tags 1, 3, 4 complete normally. Required:
  - tag 1 commits, then tag 2 commits with `flush=1`, `flush_pc=0x100`;
  - tags 3 and 4 never commit;
  - the next cycle shows `newTag=1`, `isFull=0`.
- **Stall and dual CDB.** Hold `rdy_in=0` for 3 cycles with a ready head → no commit and state frozen; commit occurs after `rdy_in` returns. Drive both CDBs with tag 4 (RS 0x1, LSB 0x2) → tag 4 commits with value 0x1.
